// File: rtl/seg7_word_marquee.sv
// Word display driver: latches an object code and shows its word on NUM_DIGITS seven-segment digits (static/scroll/blink).
// Latency: load/mode sampled at edge k, leds/word_len/active reflect it after edge k; wrap is a registered pulse.
// Backpressure: none; load is a strobe that always wins over an animation tick in the same cycle.
// Ports: clk, reset_n (async active-low), code/load/mode (control in), leds (active-low {g..a}, digit 0 = leds[6:0]),
//        word_len (latched word length), wrap (scroll/blink period pulse), active (a load has happened since reset).
module seg7_word_marquee #(
    parameter int NUM_DIGITS = 6,
    parameter int TICK_DIV   = 12500000,
    parameter int CODE_W     = 3
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [CODE_W-1:0]       code,
    input  logic                    load,
    input  logic [1:0]              mode,
    output logic [7*NUM_DIGITS-1:0] leds,
    output logic [2:0]              word_len,
    output logic                    wrap,
    output logic                    active
);
    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

    localparam logic [6:0] G_N = 7'b1001000, G_E = 7'b0000110, G_P = 7'b0001100;
    localparam logic [6:0] G_G = 7'b0000010, G_L = 7'b1000111, G_A = 7'b0001000;
    localparam logic [6:0] G_S = 7'b0010010, G_B = 7'b0000011, G_O = 7'b0100011;
    localparam logic [6:0] G_T = 7'b0000111, G_C = 7'b1000110, G_U = 7'b1000001;
    localparam logic [6:0] G_BLANK = 7'b1111111;

    localparam logic [1:0] MODE_SCROLL = 2'b01;
    localparam logic [1:0] MODE_BLINK  = 2'b10;

    logic [CODE_W-1:0] code_q;
    logic [1:0]        mode_q;
    logic [PW-1:0]     presc;
    logic [3:0]        offset;     // scroll period is at most 8 + 6 = 14
    logic              phase;      // 0 = visible, 1 = hidden

    logic [7:0][6:0]   word_arr;   // [0] is the leftmost char
    logic [2:0]        len_raw;
    logic [2:0]        len;
    logic [3:0]        period;
    logic              tick;
    logic              restart;
    logic [31:0]       code_ext;

    assign code_ext = 32'(code_q);

    // Word table lookup; unused and out-of-range codes fall through to blank.
    always_comb begin
        word_arr = {8{G_BLANK}};
        len_raw  = 3'd0;
        case (code_ext)
            32'd0: begin
                word_arr[0] = G_P; word_arr[1] = G_E; word_arr[2] = G_N;
                len_raw = 3'd3;
            end
            32'd1: begin
                word_arr[0] = G_G; word_arr[1] = G_L; word_arr[2] = G_A;
                word_arr[3] = G_S; word_arr[4] = G_S;
                len_raw = 3'd5;
            end
            32'd3: begin
                word_arr[0] = G_B; word_arr[1] = G_O; word_arr[2] = G_T;
                word_arr[3] = G_T; word_arr[4] = G_L; word_arr[5] = G_E;
                len_raw = 3'd6;
            end
            32'd4: begin
                word_arr[0] = G_C; word_arr[1] = G_U; word_arr[2] = G_P;
                len_raw = 3'd3;
            end
            32'd5: begin
                word_arr[0] = G_S; word_arr[1] = G_P; word_arr[2] = G_O;
                word_arr[3] = G_O; word_arr[4] = G_N;
                len_raw = 3'd5;
            end
            32'd6: begin
                word_arr[0] = G_A; word_arr[1] = G_P; word_arr[2] = G_P;
                word_arr[3] = G_L; word_arr[4] = G_E;
                len_raw = 3'd5;
            end
            default: begin
                word_arr = {8{G_BLANK}};
                len_raw  = 3'd0;
            end
        endcase
    end

    // Before the first load the latched code is meaningless, so treat it as a blank word.
    assign len      = active ? len_raw : 3'd0;
    assign word_len = len;
    assign period   = 4'(NUM_DIGITS) + {1'b0, len};
    assign tick     = (presc == PRESC_MAX);
    assign restart  = load | (mode != mode_q);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            code_q <= '0;
            mode_q <= 2'b00;
            presc  <= '0;
            offset <= 4'd0;
            phase  <= 1'b0;
            wrap   <= 1'b0;
            active <= 1'b0;
        end else if (restart) begin
            // Load or mode change restarts the animation and suppresses any tick this cycle.
            presc  <= '0;
            offset <= 4'd0;
            phase  <= 1'b0;
            wrap   <= 1'b0;
            mode_q <= mode;
            if (load) begin
                code_q <= code;
                active <= 1'b1;
            end
        end else begin
            wrap  <= 1'b0;
            presc <= tick ? '0 : presc + 1'b1;
            if (tick) begin
                if (mode_q == MODE_SCROLL) begin
                    if (offset == period - 4'd1) begin
                        offset <= 4'd0;
                        wrap   <= 1'b1;
                    end else begin
                        offset <= offset + 4'd1;
                    end
                end else if (mode_q == MODE_BLINK) begin
                    phase <= ~phase;
                    wrap  <= phase;   // hidden -> visible completes a blink cycle
                end
            end
        end
    end

    // Per-digit image; d is the digit index (0 = rightmost), j = NUM_DIGITS-1-d its position from the left.
    int         idx;
    logic [6:0] seg_stat;
    logic [6:0] seg_scr;
    logic [6:0] seg;

    always_comb begin
        leds     = '1;
        idx      = 0;
        seg_stat = G_BLANK;
        seg_scr  = G_BLANK;
        seg      = G_BLANK;
        for (int d = 0; d < NUM_DIGITS; d++) begin
            seg_stat = G_BLANK;
            if (d < int'(len))
                seg_stat = word_arr[3'(int'(len) - 1 - d)];
            // Stream is NUM_DIGITS blanks then the word; offset < period and j < period, so one subtraction wraps.
            idx = int'(offset) + (NUM_DIGITS - 1 - d);
            if (idx >= int'(period))
                idx = idx - int'(period);
            seg_scr = (idx >= NUM_DIGITS) ? word_arr[3'(idx - NUM_DIGITS)] : G_BLANK;
            case (mode_q)
                MODE_SCROLL: seg = seg_scr;
                MODE_BLINK:  seg = phase ? G_BLANK : seg_stat;
                default:     seg = seg_stat;
            endcase
            leds[7*d +: 7] = seg;
        end
    end
endmodule

// File: tb/tb_seg7_word_marquee.sv
module tb_seg7_word_marquee;
    localparam int TD = 4;

    localparam logic [6:0] G_N = 7'b1001000, G_E = 7'b0000110, G_P = 7'b0001100;
    localparam logic [6:0] G_G = 7'b0000010, G_L = 7'b1000111, G_A = 7'b0001000;
    localparam logic [6:0] G_S = 7'b0010010, G_B = 7'b0000011, G_O = 7'b0100011;
    localparam logic [6:0] G_T = 7'b0000111, G_C = 7'b1000110, G_U = 7'b1000001;
    localparam logic [6:0] G_BLANK = 7'b1111111;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [2:0]  code;
    logic        load;
    logic [1:0]  mode;
    logic [41:0] leds6;
    logic [27:0] leds4;
    logic [2:0]  word_len6, word_len4;
    logic        wrap6, wrap4, active6, active4;

    int n_cmp = 0;
    int n_err = 0;

    // Reference state: what the spec says is latched, plus edges elapsed since the last restart.
    bit m_active;
    int m_code;
    int m_mode;
    int m_n;

    always #5 clk = ~clk;

    seg7_word_marquee #(.NUM_DIGITS(6), .TICK_DIV(TD), .CODE_W(3)) dut6 (
        .clk(clk), .reset_n(reset_n), .code(code), .load(load), .mode(mode),
        .leds(leds6), .word_len(word_len6), .wrap(wrap6), .active(active6));

    seg7_word_marquee #(.NUM_DIGITS(4), .TICK_DIV(TD), .CODE_W(3)) dut4 (
        .clk(clk), .reset_n(reset_n), .code(code), .load(load), .mode(mode),
        .leds(leds4), .word_len(word_len4), .wrap(wrap4), .active(active4));

    function automatic string word_of(int c);
        case (c)
            0: return "PEN";
            1: return "GLASS";
            3: return "bottLE";
            4: return "CUP";
            5: return "SPooN";
            6: return "APPLE";
            default: return "";
        endcase
    endfunction

    function automatic logic [6:0] glyph(byte ch);
        case (ch)
            "N": return G_N;  "E": return G_E;  "P": return G_P;
            "G": return G_G;  "L": return G_L;  "A": return G_A;
            "S": return G_S;  "b": return G_B;  "o": return G_O;
            "t": return G_T;  "C": return G_C;  "U": return G_U;
            default: return G_BLANK;
        endcase
    endfunction

    function automatic string cur_word();
        return m_active ? word_of(m_code) : "";
    endfunction

    function automatic logic [55:0] exp_leds(int n);
        logic [55:0] r;
        logic [6:0]  g;
        string w;
        int len, ticks, p, s;
        r = '1;
        w = cur_word();
        len = w.len();
        ticks = m_n / TD;
        p = n + len;
        for (int d = 0; d < n; d++) begin
            g = (d < len) ? glyph(w[len - 1 - d]) : G_BLANK;
            if (m_mode == 1) begin
                s = ((ticks % p) + (n - 1 - d)) % p;
                g = (s < n) ? G_BLANK : glyph(w[s - n]);
            end else if (m_mode == 2 && (ticks % 2) == 1) begin
                g = G_BLANK;
            end
            r[7*d +: 7] = g;
        end
        return r;
    endfunction

    function automatic bit exp_wrap(int n);
        int ticks;
        if (m_n == 0 || (m_n % TD) != 0) return 1'b0;
        ticks = m_n / TD;
        if (m_mode == 1) return (ticks % (n + cur_word().len())) == 0;
        if (m_mode == 2) return (ticks % 2) == 0;
        return 1'b0;
    endfunction

    task automatic model_reset();
        m_active = 1'b0;
        m_code = 0;
        m_mode = 0;
        m_n = 0;
    endtask

    task automatic model_edge();
        if (!reset_n) begin
            model_reset();
        end else if (load || int'(mode) != m_mode) begin
            m_n = 0;
            m_mode = int'(mode);
            if (load) begin
                m_code = int'(code);
                m_active = 1'b1;
            end
        end else begin
            m_n++;
        end
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic [55:0] e6, e4;
        e6 = exp_leds(6);
        e4 = exp_leds(4);
        check({tag, "/leds6"}, 64'(leds6), 64'(e6[41:0]));
        check({tag, "/leds4"}, 64'(leds4), 64'(e4[27:0]));
        check({tag, "/len6"}, 64'(word_len6), 64'(cur_word().len()));
        check({tag, "/len4"}, 64'(word_len4), 64'(cur_word().len()));
        check({tag, "/wrap6"}, 64'(wrap6), 64'(exp_wrap(6)));
        check({tag, "/wrap4"}, 64'(wrap4), 64'(exp_wrap(4)));
        check({tag, "/active"}, 64'({active6, active4}), 64'({m_active, m_active}));
        check({tag, "/xchk"}, 64'($isunknown({leds6, leds4})), 64'(0));
    endtask

    task automatic cycle(input string tag);
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all(tag);
    endtask

    task automatic do_load(input string tag, input logic [2:0] c, input logic [1:0] m);
        code = c;
        mode = m;
        load = 1'b1;
        cycle(tag);
        load = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0;
        load = 1'b0;
        code = 3'd0;
        mode = 2'd0;
        model_reset();
        @(negedge clk);
        check_all("reset");
        check("reset_leds_const", 64'(leds6), 64'({42{1'b1}}));
        cycle("reset_hold");
        reset_n = 1'b1;
        cycle("idle");

        // Static PEN, held for 100 cycles.
        do_load("pen_load", 3'd0, 2'd0);
        check("pen_const", 64'(leds6), 64'({{3{G_BLANK}}, G_P, G_E, G_N}));
        check("pen_len_const", 64'(word_len6), 64'(3));
        for (int i = 0; i < 100; i++) cycle("pen_hold");
        check("pen_hold_const", 64'(leds6[20:0]), 64'({G_P, G_E, G_N}));

        // Scroll CUP through one full period (9 ticks = 36 cycles) and a bit beyond.
        do_load("cup_load", 3'd4, 2'd1);
        check("cup_blank_const", 64'(leds6), 64'({42{1'b1}}));
        for (int i = 0; i < 40; i++) begin
            cycle("cup_scroll");
            if (i == 3)  check("cup_tick1_c", 64'(leds6[6:0]), 64'(G_C));
            if (i == 11) check("cup_tick3_cup", 64'(leds6[20:0]), 64'({G_C, G_U, G_P}));
            if (i == 35) check("cup_wrap_pulse", 64'({wrap6, leds6}), 64'({1'b1, {42{1'b1}}}));
        end

        // Blink bottLE.
        do_load("blink_load", 3'd3, 2'd2);
        for (int i = 0; i < 20; i++) begin
            cycle("blink");
            if (i == 3) check("blink_hidden", 64'(leds6), 64'({42{1'b1}}));
            if (i == 7) check("blink_wrap", 64'({wrap6, leds6}),
                              64'({1'b1, G_B, G_O, G_T, G_T, G_L, G_E}));
        end

        // Blank codes.
        do_load("code7", 3'd7, 2'd0);
        check("code7_const", 64'({word_len6, leds6}), 64'({3'd0, {42{1'b1}}}));
        cycle("code7_hold");
        do_load("code2", 3'd2, 2'd0);
        check("code2_const", 64'({word_len6, leds6}), 64'({3'd0, {42{1'b1}}}));

        // Scroll CUP, then reload SPooN exactly on the wrapping tick: no wrap, offset restarts.
        do_load("cup2_load", 3'd4, 2'd1);
        for (int i = 0; i < 35; i++) cycle("cup2_scroll");
        do_load("spoon_on_tick", 3'd5, 2'd1);
        check("spoon_no_wrap", 64'({wrap6, leds6}), 64'({1'b0, {42{1'b1}}}));
        for (int i = 0; i < 14; i++) cycle("spoon_scroll");

        // Asynchronous reset mid-scroll blanks at once, without a clock edge.
        #1 reset_n = 1'b0;
        model_reset();
        #1 check_all("rst_async");
        check("rst_async_const", 64'({active6, leds6}), 64'({1'b0, {42{1'b1}}}));
        @(negedge clk);
        reset_n = 1'b1;
        cycle("rst_release");

        // 4-digit instance truncates GLASS to its tail.
        do_load("glass_load", 3'd1, 2'd0);
        check("glass4_const", 64'(leds4), 64'({G_L, G_A, G_S, G_S}));
        mode = 2'd1;
        for (int i = 0; i < 12; i++) cycle("glass_mode_chg");

        // Randomised traffic against the model.
        for (int i = 0; i < 800; i++) begin
            load = ($urandom_range(0, 5) == 0);
            code = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 19) == 0) mode = 2'($urandom_range(0, 3));
            reset_n = ($urandom_range(0, 199) != 0);
            cycle("random");
        end
        load = 1'b0;
        reset_n = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
